// File: rtl/regfile_wb_if.sv
// rtl/regfile_wb_if.sv - register file read/write-back/flags signal bundle
interface regfile_wb_if #(
    parameter int n      = 8,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [n-1:0]      a_out;
    logic [n-1:0]      b_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [n-1:0]      wr_data;
    logic              flags_en;
    logic [3:0]        flags_in;
    logic [3:0]        flags_out;
    logic [n-1:0]      dbg_out;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, flags_en, flags_in,
        input  a_out, b_out, flags_out, dbg_out
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, flags_en, flags_in,
        output a_out, b_out, flags_out, dbg_out
    );
endinterface

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - register file with write-back, status flags and R1 debug copy (optional REGFILE_BYPASS_EN)
module regfile_wb #(
    parameter int n      = 8,
    parameter int ADDR_W = 3
) (
    input  logic         Clock,
    input  logic         nReset,
    regfile_wb_if.slave  bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [n-1:0] regs [NREG];
    logic [3:0]   flags_q;
    logic [n-1:0] a_val;
    logic [n-1:0] b_val;

    // Register array: R0 is never written so it stays at its reset value of zero
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wr_en && (bus.wr_addr != '0)) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Status register holds the last ALU flags captured, independent of write-back
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            flags_q <= '0;
        end else if (bus.flags_en) begin
            flags_q <= bus.flags_in;
        end
    end

    // Read port A: stored value, R0 forced to zero, optional same-cycle forwarding
    always_comb begin
        a_val = regs[bus.rd_addr_a];
        if (bus.rd_addr_a == '0) begin
            a_val = '0;
        end
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed during reset so the ports read zero then
        if (nReset && bus.wr_en && (bus.wr_addr != '0) && (bus.wr_addr == bus.rd_addr_a)) begin
            a_val = bus.wr_data;
        end
`endif
    end

    // Read port B: identical to port A, fully independent address
    always_comb begin
        b_val = regs[bus.rd_addr_b];
        if (bus.rd_addr_b == '0) begin
            b_val = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (nReset && bus.wr_en && (bus.wr_addr != '0) && (bus.wr_addr == bus.rd_addr_b)) begin
            b_val = bus.wr_data;
        end
`endif
    end

    assign bus.a_out     = a_val;
    assign bus.b_out     = b_val;
    assign bus.flags_out = flags_q;
    // R1 storage is itself a flop, so the debug copy shares its edge timing exactly
    assign bus.dbg_out   = regs[1];

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - scoreboard testbench for regfile_wb
module tb_regfile_wb;
    logic Clock;
    logic nReset;

    regfile_wb_if #(.n(8), .ADDR_W(3)) bus ();

    regfile_wb #(.n(8), .ADDR_W(3)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t sb[$];
    int   tick   = 0;
    int   checks = 0;
    int   errors = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    // Monitor: pops expectations and compares against the presented outputs
    initial begin
        chk_t       c;
        logic [7:0] act;
        forever begin
            @(tick);
            while (sb.size() > 0) begin
                c = sb.pop_front();
                case (c.sel)
                    0:       act = bus.a_out;
                    1:       act = bus.b_out;
                    2:       act = {4'b0000, bus.flags_out};
                    default: act = bus.dbg_out;
                endcase
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %02h expected %02h at %0t", c.name, act, c.exp, $time);
                end
            end
        end
    end

    task automatic expect_out(input int sel, input logic [7:0] exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic sample();
        tick++;
        #1;
    endtask

    task automatic next_edge();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb);
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
    endtask

    initial begin
        logic [7:0] byp_exp;
        nReset = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        bus.flags_en = 1'b0;
        bus.flags_in = 4'b0000;
        next_edge();
        next_edge();

        expect_out(2, 8'h00, "reset_flags");
        expect_out(3, 8'h00, "reset_dbg");
        expect_out(0, 8'h00, "reset_a");
        sample();

        nReset = 1'b1;
        // Seed state so the later reset has something to clear
        drive(1'b1, 3'd3, 8'h11, 3'd3, 3'd1);
        bus.flags_en = 1'b1;
        bus.flags_in = 4'b1010;
        next_edge();
        drive(1'b1, 3'd1, 8'h33, 3'd3, 3'd1);
        bus.flags_en = 1'b0;
        next_edge();
        expect_out(0, 8'h11, "seed_r3");
        expect_out(1, 8'h33, "seed_r1");
        expect_out(2, 8'h0A, "seed_flags");
        sample();

        // Reset mid-cycle while a write to R3 is pending
        drive(1'b1, 3'd3, 8'hAA, 3'd3, 3'd3);
        nReset = 1'b0;
        #1;
        expect_out(0, 8'h00, "rst_mid_r3");
        expect_out(2, 8'h00, "rst_mid_flags");
        expect_out(3, 8'h00, "rst_mid_dbg");
        sample();
        next_edge();
        expect_out(0, 8'h00, "rst_edge_r3");
        expect_out(1, 8'h00, "rst_edge_r3_b");
        sample();
        nReset = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd3);
        next_edge();
        expect_out(0, 8'h00, "rst_after_r3");
        sample();

        // Write/readback
        drive(1'b1, 3'd2, 8'd45, 3'd0, 3'd0);
        next_edge();
        drive(1'b1, 3'd5, 8'hE8, 3'd0, 3'd0);
        next_edge();
        drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd2);
        #1;
        expect_out(0, 8'hE8, "rd_a_r5");
        expect_out(1, 8'd45, "rd_b_r2");
        sample();
        drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd5);
        #1;
        expect_out(0, 8'hE8, "same_addr_a");
        expect_out(1, 8'hE8, "same_addr_b");
        sample();

        // R0 hardwire
        drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0);
        #1;
        expect_out(0, 8'h00, "r0_pre");
        sample();
        next_edge();
        expect_out(0, 8'h00, "r0_post");
        expect_out(1, 8'h00, "r0_post_b");
        sample();

        // Flags: load, then hold
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        bus.flags_en = 1'b1;
        bus.flags_in = 4'b1100;
        next_edge();
        expect_out(2, 8'h0C, "flags_load");
        sample();
        bus.flags_en = 1'b0;
        bus.flags_in = 4'b0011;
        next_edge();
        expect_out(2, 8'h0C, "flags_hold");
        sample();

        // Flags and write in the same edge
        drive(1'b1, 3'd6, 8'h09, 3'd6, 3'd0);
        bus.flags_en = 1'b1;
        bus.flags_in = 4'b0101;
        next_edge();
        bus.flags_en = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd0);
        expect_out(2, 8'h05, "flags_with_wr");
        expect_out(0, 8'h09, "wr_with_flags");
        sample();

        // Bypass
        drive(1'b1, 3'd4, 8'd1, 3'd0, 3'd0);
        next_edge();
        drive(1'b1, 3'd4, 8'd7, 3'd4, 3'd4);
`ifdef REGFILE_BYPASS_EN
        byp_exp = 8'd7;
`else
        byp_exp = 8'd1;
`endif
        #1;
        expect_out(0, byp_exp, "bypass_pre_a");
        expect_out(1, byp_exp, "bypass_pre_b");
        sample();
        next_edge();
        drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd4);
        expect_out(0, 8'd7, "bypass_post_a");
        sample();

        // Debug copy of R1
        drive(1'b1, 3'd1, 8'b01010101, 3'd0, 3'd0);
        #1;
        expect_out(3, 8'h00, "dbg_pre_edge");
        sample();
        next_edge();
        expect_out(3, 8'h55, "dbg_r1");
        sample();
        drive(1'b1, 3'd7, 8'h99, 3'd7, 3'd1);
        next_edge();
        expect_out(3, 8'h55, "dbg_other_wr");
        expect_out(0, 8'h99, "r7_write");
        expect_out(1, 8'h55, "r1_read");
        sample();

        // Back-to-back writes to the same register
        drive(1'b1, 3'd6, 8'h01, 3'd6, 3'd2);
        next_edge();
        drive(1'b1, 3'd6, 8'h02, 3'd6, 3'd2);
        next_edge();
        drive(1'b0, 3'd6, 8'h03, 3'd6, 3'd2);
        next_edge();
        expect_out(0, 8'h02, "b2b_last");
        expect_out(1, 8'd45, "hold_r2");
        sample();

        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
